cache_ctrl: RTL and testbench

Sequencing controller for the direct-mapped, write-back, write-allocate data cache in front of the 64-word data memory. It owns the line storage (tag, valid, dirty, 4-word block per line), serves one processor request at a time, and drives a word-serial handshake to data memory for dirty-line writeback and line refill. It sits between the core's load/store port and `data_mem` inside `top`.

---
 rtl/cache_pkg.sv | 45 ++++
 rtl/cache_store.sv | 63 ++++++
 rtl/cache_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM states and address helpers for the data cache.
package cache_pkg;

    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 6;
    localparam int NUM_LINES  = 4;
    localparam int LINE_WORDS = 4;
    localparam int TAG_W      = 2;
    localparam int IDX_W      = 2;
    localparam int OFF_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(
        input logic [ADDR_W-1:0] a
    );
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(
        input logic [ADDR_W-1:0] a
    );
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(
        input logic [ADDR_W-1:0] a
    );
        return a[OFF_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(
        input logic [TAG_W-1:0] t,
        input logic [IDX_W-1:0] i,
        input logic [OFF_W-1:0] o
    );
        return {t, i, o};
    endfunction

endpackage

// File: rtl/cache_store.sv
// Line storage: tag, valid, dirty and data block per line.
// Reads are combinational on idx; all writes land on the clock edge.
module cache_store
    import cache_pkg::*;
(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [IDX_W-1:0]                     idx,
    output logic [TAG_W-1:0]                     rd_tag,
    output logic                                 rd_valid,
    output logic                                 rd_dirty,
    output logic [LINE_WORDS-1:0][WORD_W-1:0]    rd_line,
    input  logic                                 word_we,
    input  logic [OFF_W-1:0]                     wr_off,
    input  logic [WORD_W-1:0]                    wr_word,
    input  logic                                 fill_we,
    input  logic [TAG_W-1:0]                     wr_tag,
    input  logic                                 set_dirty,
    input  logic                                 clr_dirty
);

    logic [TAG_W-1:0]  tag   [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [WORD_W-1:0] block [NUM_LINES][LINE_WORDS];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag[i] <= '0;
                for (int j = 0; j < LINE_WORDS; j++) begin
                    block[i][j] <= '0;
                end
            end
        end else begin
            if (word_we) begin
                block[idx][wr_off] <= wr_word;
            end
            if (fill_we) begin
                tag[idx]   <= wr_tag;
                valid[idx] <= 1'b1;
            end
            if (set_dirty) begin
                dirty[idx] <= 1'b1;
            end else if (clr_dirty) begin
                dirty[idx] <= 1'b0;
            end
        end
    end

    assign rd_tag   = tag[idx];
    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];

    always_comb begin
        for (int j = 0; j < LINE_WORDS; j++) begin
            rd_line[j] = block[idx][j];
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller.
// Serves one cpu request at a time; word-serial bursts to memory.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            state;
    logic [OFF_W-1:0]  cnt;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  ntag;
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  nxt;
    logic              last;
    logic              hit;

    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              rd_dirty;
    logic [LINE_WORDS-1:0][WORD_W-1:0] rd_line;

    logic              word_we;
    logic [OFF_W-1:0]  wr_off;
    logic [WORD_W-1:0] wr_word;
    logic              fill_we;
    logic              set_dirty;
    logic              clr_dirty;

    assign idx  = addr_idx(req_addr);
    assign ntag = addr_tag(req_addr);
    assign off  = addr_off(req_addr);
    assign nxt  = cnt + 1'b1;
    assign last = (cnt == OFF_W'(LINE_WORDS - 1));
    assign hit  = rd_valid && (rd_tag == ntag);

    cache_store u_store (
        .clock     (clock),
        .reset     (reset),
        .idx       (idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .wr_off    (wr_off),
        .wr_word   (wr_word),
        .fill_we   (fill_we),
        .wr_tag    (ntag),
        .set_dirty (set_dirty),
        .clr_dirty (clr_dirty)
    );

    always_comb begin
        word_we   = 1'b0;
        wr_off    = off;
        wr_word   = req_wdata;
        fill_we   = 1'b0;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;
        unique case (state)
            LOOKUP: begin
                if (hit && req_we) begin
                    word_we   = 1'b1;
                    set_dirty = 1'b1;
                end
            end
            WRITEBACK: begin
                clr_dirty = mem_ready && last;
            end
            REFILL: begin
                if (mem_ready) begin
                    word_we = 1'b1;
                    wr_off  = cnt;
                    wr_word = mem_rdata;
                    fill_we = last;
                    clr_dirty = last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A request still high during the ready pulse is the old one.
                    if (cpu_req && !cpu_ready) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    cnt <= '0;
                    if (hit) begin
                        if (!req_we) begin
                            cpu_rdata <= rd_line[off];
                        end
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (rd_valid && rd_dirty) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= mk_addr(rd_tag, idx, '0);
                        mem_wdata <= rd_line[0];
                        state     <= WRITEBACK;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= mk_addr(ntag, idx, '0);
                        state    <= REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        if (last) begin
                            cnt      <= '0;
                            mem_we   <= 1'b0;
                            mem_addr <= mk_addr(ntag, idx, '0);
                            state    <= REFILL;
                        end else begin
                            cnt       <= nxt;
                            mem_addr  <= mk_addr(rd_tag, idx, nxt);
                            mem_wdata <= rd_line[nxt];
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        if (last) begin
                            cnt     <= '0;
                            mem_req <= 1'b0;
                            state   <= LOOKUP;
                        end else begin
                            cnt      <= nxt;
                            mem_addr <= mk_addr(ntag, idx, nxt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed and random checks of cache_ctrl against a behavioural cache model
// and a word memory that answers each word after a programmable latency.
module tb_cache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    int          lat;
    int          wcnt;
    logic [38:0] act_ops[$];

    logic [31:0] refmem [64];
    logic        m_valid [4];
    logic        m_dirty [4];
    int          m_tag [4];
    logic [31:0] m_line [4][4];
    logic [38:0] exp_ops[$];
    logic [31:0] exp_rdata;
    logic        exp_hit;

    cache_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial forever #5 clock = ~clock;

    // Memory: one word completes lat cycles after its address is seen.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wcnt = 0;
        forever begin
            @(posedge clock);
            #1;
            mem_ready = 1'b0;
            if (mem_req === 1'b1) begin
                wcnt++;
                if (wcnt >= lat) begin
                    wcnt = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        act_ops.push_back({1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem[mem_addr];
                        act_ops.push_back({1'b0, mem_addr, mem_rdata});
                    end
                    mem_ready = 1'b1;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i] = 0;
            for (int j = 0; j < 4; j++) m_line[i][j] = '0;
        end
    endtask

    // Plain cache semantics: evict dirty victim, fetch line, then access.
    task automatic model_access(input logic we, input int addr,
                                input logic [31:0] wdata);
        int t, ix, o, a;
        t  = addr / 16;
        ix = (addr / 4) % 4;
        o  = addr % 4;
        exp_ops.delete();
        exp_hit = m_valid[ix] && (m_tag[ix] == t);
        if (!exp_hit) begin
            if (m_valid[ix] && m_dirty[ix]) begin
                for (int w = 0; w < 4; w++) begin
                    a = m_tag[ix] * 16 + ix * 4 + w;
                    refmem[a] = m_line[ix][w];
                    exp_ops.push_back({1'b1, 6'(a), m_line[ix][w]});
                end
            end
            for (int w = 0; w < 4; w++) begin
                a = t * 16 + ix * 4 + w;
                m_line[ix][w] = refmem[a];
                exp_ops.push_back({1'b0, 6'(a), refmem[a]});
            end
            m_tag[ix] = t;
            m_valid[ix] = 1'b1;
            m_dirty[ix] = 1'b0;
        end
        if (we) begin
            m_line[ix][o] = wdata;
            m_dirty[ix] = 1'b1;
        end else begin
            exp_rdata = m_line[ix][o];
        end
    endtask

    task automatic do_access(input logic we, input int addr,
                             input logic [31:0] wdata,
                             output logic [31:0] rdata);
        int cycles, mreq, extra;
        logic got;
        model_access(we, addr, wdata);
        act_ops.delete();
        rdata = 'x;
        @(posedge clock);
        #1;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = 6'(addr);
        cpu_wdata = wdata;
        cycles = 0;
        mreq = 0;
        got = 1'b0;
        while (!got && cycles < 400) begin
            @(posedge clock);
            #1;
            cycles++;
            if (mem_req) mreq++;
            if (cpu_ready) begin
                got = 1'b1;
                rdata = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        extra = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (cpu_ready) extra++;
        end
        check("done", got, 1);
        check("extra_ready", extra, 0);
        if (!we) check("rdata", rdata, exp_rdata);
        if (exp_hit) begin
            check("hit_latency", cycles, 2);
            check("hit_mem_req", mreq, 0);
        end
        check("op_count", act_ops.size(), exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < act_ops.size(); i++)
            check("mem_op", act_ops[i], exp_ops[i]);
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            check("valid", dut.u_store.valid[i], m_valid[i]);
            if (m_valid[i]) begin
                check("dirty", dut.u_store.dirty[i], m_dirty[i]);
                check("tag", dut.u_store.tag[i], m_tag[i]);
                for (int j = 0; j < 4; j++)
                    check("block", dut.u_store.block[i][j], m_line[i][j]);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        lat = 1;
        reset = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = i;
            refmem[i] = i;
        end
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_valid", dut.u_store.valid, 0);
        check("rst_dirty", dut.u_store.dirty, 0);
        reset = 1'b0;

        do_access(1'b0, 6'h05, 0, rd);
        check("cold_rdata", rd, 5);
        check("cold_valid1", dut.u_store.valid[1], 1);
        check("cold_tag1", dut.u_store.tag[1], 0);
        check("cold_dirty1", dut.u_store.dirty[1], 0);

        do_access(1'b0, 6'h06, 0, rd);
        check("hit_rdata", rd, 6);

        do_access(1'b1, 6'h04, 100, rd);
        check("st_block10", dut.u_store.block[1][0], 100);
        check("st_dirty1", dut.u_store.dirty[1], 1);
        check("st_mem4", mem[4], 4);

        do_access(1'b0, 6'h14, 0, rd);
        check("conf_rdata", rd, 20);
        check("conf_mem4", mem[4], 100);
        check("conf_tag1", dut.u_store.tag[1], 1);
        check("conf_dirty1", dut.u_store.dirty[1], 0);

        lat = 3;
        do_access(1'b1, 6'h3F, 7, rd);
        check("smiss_block33", dut.u_store.block[3][3], 7);
        check("smiss_dirty3", dut.u_store.dirty[3], 1);
        check_all();

        lat = 1;
        act_ops.delete();
        @(posedge clock);
        #1;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 6'h29;
        n = 0;
        while (act_ops.size() < 2 && n < 100) begin
            @(posedge clock);
            #2;
            n++;
        end
        check("rst_burst_seen", act_ops.size() >= 2, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge clock);
        #2;
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_cpu_ready", cpu_ready, 0);
        check("mid_rst_valid", dut.u_store.valid, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        do_access(1'b0, 6'h29, 0, rd);
        check("post_rst_rdata", rd, 41);

        for (int k = 0; k < 40; k++) begin
            lat = $urandom_range(1, 3);
            do_access(1'($urandom_range(0, 1)), $urandom_range(0, 63),
                      $urandom, rd);
        end
        check_all();
        for (int i = 0; i < 64; i++) check("mem_final", mem[i], refmem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
